conv_sram_sched: RTL and testbench

CONV_SRAM_SCHED -- requirements
Module: conv_sram_sched

---
 rtl/conv_sram_pkg.sv | 13 +
 rtl/conv_rd_fifo2.sv | 48 ++++
 rtl/conv_sram_sched.sv | 159 +++++++++++++++
 tb/tb_conv_sram_sched.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sram_pkg.sv
// Shared widths, transfer sizes and FSM state encoding for the conv SRAM scheduler.
package conv_sram_pkg;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int RD_BYTES       = 16;
  localparam int WR_BYTES       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/conv_rd_fifo2.sv
// Two-entry in-order buffer for SRAM read lines; head entry holds still until popped.
module conv_rd_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2);
  assign w_do_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/conv_sram_sched.sv
// Job scheduler streaming strided 16-byte SRAM reads out and 8-byte writes in.
// Define SRAM_SCHED_HAZARD_EN to defer reads that overlap a same-cycle write.
module conv_sram_sched
  import conv_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          cfg_rd_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_rd_stride,
  input  logic [ADDR_WIDTH-1:0]          cfg_wr_base,
  input  logic [7:0]                     cfg_rd_num,
  input  logic [7:0]                     cfg_wr_num,
  output logic                           busy,
  output logic                           done,
  output logic                           sram_re,
  output logic [ADDR_WIDTH-1:0]          sram_addr_r,
  input  logic [RD_BYTES*DATA_WIDTH-1:0] sram_dout,
  output logic                           sram_we,
  output logic [ADDR_WIDTH-1:0]          sram_addr_w,
  output logic [WR_BYTES*DATA_WIDTH-1:0] sram_din,
  output logic [RD_BYTES*DATA_WIDTH-1:0] rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  input  logic [WR_BYTES*DATA_WIDTH-1:0] wr_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output state_t                         dbg_state
);
  localparam int RW = RD_BYTES * DATA_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_rd_stride;
  logic [7:0]            r_rd_num;
  logic [7:0]            r_rd_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_num;
  logic [7:0]            r_wr_cnt;
  logic                  r_inflight;

  logic                  w_run;
  logic                  w_fifo_valid;
  logic [RW-1:0]         w_fifo_data;
  logic [1:0]            w_fifo_count;
  logic                  w_pop;
  logic [1:0]            w_occ_after;
  logic                  w_space;
  logic                  w_hazard;
  logic                  w_re;
  logic                  w_wr_ready;
  logic                  w_we;
  logic                  w_rd_done;
  logic                  w_wr_done;

  // Both streams: a beat transfers on a cycle where valid && ready; the
  // sender holds its payload unchanged while valid is high and ready is low.
  assign w_run        = (r_state == RUN) && !rst;
  assign w_pop        = w_fifo_valid && rd_ready && !rst;
  assign w_occ_after  = w_fifo_count - {1'b0, w_pop};
  assign w_space      = ({1'b0, w_occ_after} + {2'b00, r_inflight}) < 3'd2;
  assign w_wr_ready   = w_run && (r_wr_cnt < r_wr_num);
  assign w_we         = w_wr_ready && wr_valid;

`ifdef SRAM_SCHED_HAZARD_EN
  logic [ADDR_WIDTH:0] w_r_lo, w_r_hi, w_w_lo, w_w_hi;
  // Windows compared unwrapped so a line crossing the top never aliases low.
  assign w_r_lo   = {1'b0, r_rd_addr};
  assign w_r_hi   = w_r_lo + (ADDR_WIDTH+1)'(RD_BYTES - 1);
  assign w_w_lo   = {1'b0, r_wr_addr};
  assign w_w_hi   = w_w_lo + (ADDR_WIDTH+1)'(WR_BYTES - 1);
  assign w_hazard = w_we && (w_r_lo <= w_w_hi) && (w_w_lo <= w_r_hi);
`else
  assign w_hazard = 1'b0;
`endif

  assign w_re      = w_run && (r_rd_cnt < r_rd_num) && w_space && !w_hazard;
  assign w_rd_done = (r_rd_cnt == r_rd_num) && !r_inflight && (w_occ_after == 2'd0);
  assign w_wr_done = ((r_wr_cnt + {7'd0, w_we}) == r_wr_num);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_rd_done && w_wr_done) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = !rst && (r_state != IDLE);
    done      = !rst && (r_state == DONE);
    dbg_state = rst ? IDLE : r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_rd_stride <= '0;
      r_rd_num    <= '0;
      r_rd_cnt    <= '0;
      r_wr_addr   <= '0;
      r_wr_num    <= '0;
      r_wr_cnt    <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_rd_addr   <= cfg_rd_base;
        r_rd_stride <= cfg_rd_stride;
        r_rd_num    <= cfg_rd_num;
        r_rd_cnt    <= '0;
        r_wr_addr   <= cfg_wr_base;
        r_wr_num    <= cfg_wr_num;
        r_wr_cnt    <= '0;
      end else begin
        if (w_re) begin
          r_rd_addr <= r_rd_addr + r_rd_stride;
          r_rd_cnt  <= r_rd_cnt + 8'd1;
        end
        if (w_we) begin
          r_wr_addr <= r_wr_addr + ADDR_WIDTH'(WR_BYTES);
          r_wr_cnt  <= r_wr_cnt + 8'd1;
        end
      end
      r_inflight <= w_re;
    end
  end

  // SRAM returns the line one cycle after sram_re; it lands straight in the buffer.
  conv_rd_fifo2 #(.W(RW)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (sram_dout),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign sram_re     = w_re;
  assign sram_addr_r = w_re ? r_rd_addr : '0;
  assign sram_we     = w_we;
  assign sram_addr_w = w_we ? r_wr_addr : '0;
  assign sram_din    = w_we ? wr_data : '0;
  assign rd_valid    = w_fifo_valid && !rst;
  assign rd_data     = rst ? '0 : w_fifo_data;
  assign wr_ready    = w_wr_ready;
endmodule

// File: tb/tb_conv_sram_sched.sv
// Bench for conv_sram_sched: behavioural SRAM, read/write scoreboards and per-scenario tasks.
module tb_conv_sram_sched;
  import conv_sram_pkg::*;

  localparam int AW = 9;
  localparam int RW = 128;
  localparam int WW = 64;

  logic          clk, rst, start;
  logic [AW-1:0] cfg_rd_base, cfg_rd_stride, cfg_wr_base;
  logic [7:0]    cfg_rd_num, cfg_wr_num;
  logic          busy, done, sram_re, sram_we;
  logic [AW-1:0] sram_addr_r, sram_addr_w;
  logic [RW-1:0] sram_dout, rd_data;
  logic [WW-1:0] sram_din, wr_data;
  logic          rd_valid, rd_ready, wr_valid, wr_ready;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]    mem     [512];
  logic [7:0]    ref_mem [512];
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] got_q [$];
  logic [AW-1:0] re_addr_q [$];
  int            re_cyc_q [$];
  logic [AW-1:0] we_addr_q [$];
  logic [WW-1:0] we_din_q [$];
  logic [AW-1:0] exp_waddr_q [$];
  logic [WW-1:0] exp_wdin_q [$];
  int            issued, popped, max_out, stall_viol, done_count, done_cyc, last_beat_cyc;
  logic          prev_stall;
  logic [RW-1:0] prev_data;

  conv_sram_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_rd_base(cfg_rd_base), .cfg_rd_stride(cfg_rd_stride), .cfg_wr_base(cfg_wr_base),
    .cfg_rd_num(cfg_rd_num), .cfg_wr_num(cfg_wr_num),
    .busy(busy), .done(done),
    .sram_re(sram_re), .sram_addr_r(sram_addr_r), .sram_dout(sram_dout),
    .sram_we(sram_we), .sram_addr_w(sram_addr_w), .sram_din(sram_din),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM model (registered read, write-after-read) ----------------
  always @(posedge clk) begin
    if (sram_re)
      for (int i = 0; i < 16; i++) sram_dout[i*8 +: 8] <= mem[sram_addr_r + AW'(i)];
    if (sram_we)
      for (int i = 0; i < 8; i++) mem[sram_addr_w + AW'(i)] <= sram_din[i*8 +: 8];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      if (sram_re) begin
        re_addr_q.push_back(sram_addr_r);
        re_cyc_q.push_back(cyc);
        issued++;
      end
      if (sram_we) begin
        we_addr_q.push_back(sram_addr_w);
        we_din_q.push_back(sram_din);
      end
      if (rd_valid && prev_stall && (rd_data !== prev_data)) stall_viol++;
      if (rd_valid && rd_ready) begin
        got_q.push_back(rd_data);
        popped++;
        last_beat_cyc = cyc;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [RW-1:0] ref_line(input logic [AW-1:0] base);
    logic [RW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = ref_mem[base + AW'(i)];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    exp_q.delete(); got_q.delete(); re_addr_q.delete(); re_cyc_q.delete();
    we_addr_q.delete(); we_din_q.delete(); exp_waddr_q.delete(); exp_wdin_q.delete();
    max_out = 0;
    stall_viol = 0;
  endtask

  task automatic start_job(input logic [AW-1:0] rb, input logic [AW-1:0] rs, input logic [7:0] rn,
                           input logic [AW-1:0] wb, input logic [7:0] wn, output int scyc);
    cfg_rd_base = rb; cfg_rd_stride = rs; cfg_rd_num = rn;
    cfg_wr_base = wb; cfg_wr_num = wn;
    start = 1'b1;
    scyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, done, rd_valid, wr_ready, sram_re, sram_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {busy, done, rd_valid, wr_ready, sram_re, sram_we});
    end
    checks++;
    if ({sram_addr_r, sram_addr_w, sram_din, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr_r=%0d addr_w=%0d din=%h rd_data=%h required all 0",
               sram_addr_r, sram_addr_w, sram_din, rd_data);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b wr_ready=%b required 0 0", busy, wr_ready);
    end
    tick();
  endtask

  task automatic test_zero_job();
    int s;
    bit seen;
    clr_logs();
    start_job(0, 0, 0, 0, 0, s);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_run: busy=%b done=%b required 1 0", busy, done);
    end
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    checks++;
    if (!seen || done_cyc !== s + 2) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d required %0d (seen=%b)", done_cyc - s, 2, seen);
    end
    checks++;
    if (re_addr_q.size() != 0 || we_addr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_no_access: re=%0d we=%0d required 0 0", re_addr_q.size(), we_addr_q.size());
    end
  endtask

  task automatic test_stream();
    int s;
    bit seen;
    logic [RW-1:0] e, g;
    clr_logs();
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(ref_line(AW'(k * 16)));
    start_job(0, 16, 4, 0, 0, s);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stream_timeout: done=0 required 1");
    end
    checks++;
    if (re_addr_q.size() != 4) begin
      errors++;
      $display("FAIL stream_re_count: got %0d required 4", re_addr_q.size());
    end
    for (int k = 0; k < re_addr_q.size() && k < 4; k++) begin
      checks++;
      if (re_addr_q[k] !== AW'(k * 16) || re_cyc_q[k] !== re_cyc_q[0] + k) begin
        errors++;
        $display("FAIL stream_re%0d: addr=%0d cyc+%0d required addr=%0d cyc+%0d",
                 k, re_addr_q[k], re_cyc_q[k] - re_cyc_q[0], k * 16, k);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stream_beats: got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL stream_data: got %h required %h", g, e);
      end
    end
    checks++;
    if (done_cyc !== last_beat_cyc + 1) begin
      errors++;
      $display("FAIL stream_done_latency: got %0d required 1", done_cyc - last_beat_cyc);
    end
  endtask

  task automatic test_backpressure();
    int s;
    bit seen;
    logic [RW-1:0] e, g;
    clr_logs();
    rd_ready = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(ref_line(AW'(64 + k * 16)));
    start_job(64, 16, 6, 0, 0, s);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      rd_ready = (n < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      seen = done;
      tick();
    end
    rd_ready = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_timeout: done=0 required 1");
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL bp_outstanding: got %0d required <=2", max_out);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes required 0", stall_viol);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_beats: got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bp_data: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_writes();
    int s, acc;
    bit seen;
    logic [AW-1:0] ea;
    logic [WW-1:0] ed;
    clr_logs();
    rd_ready = 1'b1;
    start_job(0, 0, 0, 384, 3, s);
    acc = 0;
    for (int n = 0; n < 40 && acc < 3; n++) begin
      wr_valid = n[0];
      wr_data  = {$urandom, $urandom};
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        ea = AW'(384 + 8 * acc);
        exp_waddr_q.push_back(ea);
        exp_wdin_q.push_back(wr_data);
        for (int i = 0; i < 8; i++) ref_mem[ea + AW'(i)] = wr_data[i*8 +: 8];
        acc++;
      end
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0 || acc != 3) begin
      errors++;
      $display("FAIL wr_ready_drop: wr_ready=%b accepted=%0d required 0 3", wr_ready, acc);
    end
    seen = done;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wr_timeout: done=0 required 1");
    end
    checks++;
    if (we_addr_q.size() != exp_waddr_q.size()) begin
      errors++;
      $display("FAIL wr_count: got %0d required %0d", we_addr_q.size(), exp_waddr_q.size());
    end
    while (exp_waddr_q.size() > 0 && we_addr_q.size() > 0) begin
      ea = exp_waddr_q.pop_front();
      ed = exp_wdin_q.pop_front();
      checks++;
      if (we_addr_q[0] !== ea || we_din_q[0] !== ed) begin
        errors++;
        $display("FAIL wr_beat: addr=%0d din=%h required addr=%0d din=%h", we_addr_q[0], we_din_q[0], ea, ed);
      end
      void'(we_addr_q.pop_front());
      void'(we_din_q.pop_front());
    end
  endtask

  task automatic test_wrap();
    int s;
    bit seen;
    logic [RW-1:0] e, g;
    clr_logs();
    rd_ready = 1'b1;
    exp_q.push_back(ref_line(AW'(500)));
    exp_q.push_back(ref_line(AW'(4)));
    start_job(500, 16, 2, 0, 0, s);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    checks++;
    if (!seen || re_addr_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: reads=%0d done=%b required 2 1", re_addr_q.size(), seen);
    end else begin
      checks++;
      if (re_addr_q[0] !== AW'(500) || re_addr_q[1] !== AW'(4)) begin
        errors++;
        $display("FAIL wrap_addr: got %0d,%0d required 500,4", re_addr_q[0], re_addr_q[1]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wrap_data: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_hazard();
    int s, lat;
    bit seen;
    logic [WW-1:0] wd;
    logic [RW-1:0] old_line, new_line, e, g;
    clr_logs();
    rd_ready = 1'b1;
    wd = {$urandom, $urandom};
    old_line = ref_line(AW'(384));
    for (int i = 0; i < 8; i++) ref_mem[AW'(388 + i)] = wd[i*8 +: 8];
    new_line = ref_line(AW'(384));
`ifdef SRAM_SCHED_HAZARD_EN
    exp_q.push_back(new_line);
    lat = 1;
`else
    exp_q.push_back(old_line);
    lat = 0;
`endif
    wr_valid = 1'b1;
    wr_data  = wd;
    start_job(384, 16, 1, 388, 1, s);
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL hz_write_accept: wr_ready=%b required 1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    checks++;
    if (!seen || re_cyc_q.size() != 1 || we_addr_q.size() != 1) begin
      errors++;
      $display("FAIL hz_counts: reads=%0d writes=%0d done=%b required 1 1 1", re_cyc_q.size(), we_addr_q.size(), seen);
    end else begin
      checks++;
      if (re_cyc_q[0] !== s + 1 + lat || we_addr_q[0] !== AW'(388)) begin
        errors++;
        $display("FAIL hz_timing: read at start+%0d write addr %0d required start+%0d addr 388",
                 re_cyc_q[0] - s, we_addr_q[0], 1 + lat);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL hz_data: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, s2, dc0;
    bit seen;
    logic [RW-1:0] e, g;
    clr_logs();
    rd_ready = 1'b0;
    dc0 = done_count;
    start_job(0, 16, 4, 0, 0, s);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, rd_valid, wr_ready, sram_re, sram_we} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b required 000000", {busy, done, rd_valid, wr_ready, sram_re, sram_we});
    end
    checks++;
    if ({sram_addr_r, sram_addr_w, sram_din, rd_data} !== '0) begin
      errors++;
      $display("FAIL midrst_data: addr_r=%0d addr_w=%0d din=%h rd_data=%h required all 0",
               sram_addr_r, sram_addr_w, sram_din, rd_data);
    end
    tick();
    rst = 1'b0;
    clr_logs();
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(ref_line(AW'(128 + k * 16)));
    start_job(128, 16, 3, 0, 0, s2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: busy=%b required 1", busy);
    end
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    tick();
    checks++;
    if (!seen || done_count !== dc0 + 1) begin
      errors++;
      $display("FAIL midrst_done_pulses: got %0d required 1", done_count - dc0);
    end
    checks++;
    if (re_addr_q.size() != 3 || got_q.size() != 3) begin
      errors++;
      $display("FAIL midrst_counts: reads=%0d beats=%0d required 3 3", re_addr_q.size(), got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL midrst_data: got %h required %h", g, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_rd_base = '0; cfg_rd_stride = '0; cfg_wr_base = '0;
    cfg_rd_num = '0; cfg_wr_num = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    issued = 0; popped = 0; max_out = 0; stall_viol = 0;
    done_count = 0; done_cyc = 0; last_beat_cyc = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 8'($urandom_range(0, 255));
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_zero_job();
    test_stream();
    test_backpressure();
    test_writes();
    test_wrap();
    test_hazard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
